// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI byte stream -> single-cycle register bus protocol engine.
// Latency: write strobe 1 clk after rxd_flag; first read byte on txd_data 3 clk after the
//   command byte, streamed read bytes 1 clk after each rxd_flag (prefetched).
// Backpressure: none; the SPI master paces the frame, and cs rise aborts any pending access.
// Ports:
//   clk, rst            - system clock, async active-high reset
//   cs                  - raw SPI chip select (active low, asynchronous to clk)
//   rxd_flag, rxd_out   - received-byte pulse and byte from the SPI slave
//   txd_data            - next byte to shift out on MISO
//   reg_addr, reg_wdata, reg_we, reg_re, reg_rdata - register bus (rdata valid 1 clk after re)
//   frame_active        - synchronised frame indicator
//   cmd_err             - sticky: frame ended before its command byte completed
module spi_reg_bridge #(
  parameter int unsigned ADDR_W      = 7,
  parameter bit          AUTO_INC    = 1'b1,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              rxd_flag,
  input  logic [7:0]        rxd_out,
  output logic [7:0]        txd_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              frame_active,
  output logic              cmd_err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CMD       = 3'd1;
  localparam logic [2:0] WR        = 3'd2;
  localparam logic [2:0] RD_ISSUE  = 3'd3;
  localparam logic [2:0] RD_FILL   = 3'd4;
  localparam logic [2:0] RD_STREAM = 3'd5;

  logic              cs_meta_q, cs_meta_d;
  logic              cs_s_q, cs_s_d;
  logic              cs_prev_q, cs_prev_d;
  logic [2:0]        state_q, state_d;
  logic [7:0]        txd_q, txd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              rd_pend_q, rd_pend_d;   // reg_rdata is valid this clk
  logic [7:0]        pf_buf_q, pf_buf_d;
  logic              pf_valid_q, pf_valid_d;
  logic              active_q, active_d;
  logic              cmd_err_q, cmd_err_d;

  logic              cs_fall;
  logic [ADDR_W-1:0] addr_next;

  assign cs_fall   = cs_prev_q & ~cs_s_q;
  // With AUTO_INC=0 the increment is zero, so the address holds for the whole frame.
  assign addr_next = addr_q + ADDR_W'(AUTO_INC);

  always_comb begin
    cs_meta_d  = cs;
    cs_s_d     = cs_meta_q;
    cs_prev_d  = cs_s_q;
    state_d    = state_q;
    txd_d      = txd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    rd_pend_d  = re_q;
    pf_buf_d   = pf_buf_q;
    pf_valid_d = pf_valid_q;
    active_d   = active_q;
    cmd_err_d  = cmd_err_q;

    if ((state_q != IDLE) && cs_s_q) begin
      // Frame end has priority over a byte arriving in the same clk: the byte
      // is dropped and no strobe is issued.
      state_d    = IDLE;
      active_d   = 1'b0;
      txd_d      = STATUS_BYTE;
      pf_valid_d = 1'b0;
      rd_pend_d  = 1'b0;
      if (state_q == CMD) begin
        cmd_err_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d   = CMD;
            active_d  = 1'b1;
            cmd_err_d = 1'b0;
            txd_d     = STATUS_BYTE;
          end
        end
        CMD: begin
          if (rxd_flag) begin
            addr_d = rxd_out[ADDR_W-1:0];
            if (rxd_out[7]) begin
              // reg_re is registered, so it is high during RD_ISSUE.
              state_d = RD_ISSUE;
              re_d    = 1'b1;
            end else begin
              state_d = WR;
            end
          end
        end
        WR: begin
          if (rxd_flag) begin
            wdata_d = rxd_out;
            we_d    = 1'b1;
          end
          // Advance only after the strobe has used the current address.
          if (we_q) begin
            addr_d = addr_next;
          end
        end
        RD_ISSUE: begin
          state_d = RD_FILL;
        end
        RD_FILL: begin
          // First byte goes straight to MISO; then prefetch the following one.
          txd_d   = reg_rdata;
          addr_d  = addr_next;
          re_d    = 1'b1;
          state_d = RD_STREAM;
        end
        RD_STREAM: begin
          if (rd_pend_q) begin
            pf_buf_d   = reg_rdata;
            pf_valid_d = 1'b1;
          end
          // MOSI content is ignored; the flag only marks that MISO consumed a byte.
          if (rxd_flag && pf_valid_q) begin
            txd_d      = pf_buf_q;
            pf_valid_d = 1'b0;
            addr_d     = addr_next;
            re_d       = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_meta_q  <= 1'b1;
      cs_s_q     <= 1'b1;
      cs_prev_q  <= 1'b1;
      state_q    <= IDLE;
      txd_q      <= STATUS_BYTE;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      rd_pend_q  <= 1'b0;
      pf_buf_q   <= 8'h00;
      pf_valid_q <= 1'b0;
      active_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      cs_meta_q  <= cs_meta_d;
      cs_s_q     <= cs_s_d;
      cs_prev_q  <= cs_prev_d;
      state_q    <= state_d;
      txd_q      <= txd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      rd_pend_q  <= rd_pend_d;
      pf_buf_q   <= pf_buf_d;
      pf_valid_q <= pf_valid_d;
      active_q   <= active_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign txd_data     = txd_q;
  assign reg_addr     = addr_q;
  assign reg_wdata    = wdata_q;
  assign reg_we       = we_q;
  assign reg_re       = re_q;
  assign frame_active = active_q;
  assign cmd_err      = cmd_err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed frames with a queue scoreboard on the register bus and MISO byte.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_spi_reg_bridge;

  localparam int GAP = 16;

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_a = 1'b1, cs_b = 1'b1;
  logic       flag_a = 1'b0, flag_b = 1'b0;
  logic [7:0] rxd = 8'h00;

  logic [7:0] txd_a, txd_b, wdata_a, wdata_b, rdata_a, rdata_b;
  logic [6:0] addr_a, addr_b;
  logic       we_a, we_b, re_a, re_b, act_a, act_b, err_a, err_b;

  logic [7:0] mem_a [0:127];

  wr_t        exp_wr_a [$];
  wr_t        exp_wr_b [$];
  logic [6:0] exp_rd_a [$];
  logic [7:0] exp_txd_a[$];

  int         checks = 0;
  int         errors = 0;
  logic       mon_en = 1'b0;
  logic [7:0] last_txd_a = 8'hA5;
  logic [7:0] last_txd_b = 8'hA5;
  wr_t        mw;
  logic [6:0] mr;
  logic [7:0] mt;

  always #5 clk = ~clk;

  spi_reg_bridge dut_a (
    .clk(clk), .rst(rst), .cs(cs_a), .rxd_flag(flag_a), .rxd_out(rxd),
    .txd_data(txd_a), .reg_addr(addr_a), .reg_wdata(wdata_a), .reg_we(we_a),
    .reg_re(re_a), .reg_rdata(rdata_a), .frame_active(act_a), .cmd_err(err_a)
  );

  spi_reg_bridge #(.AUTO_INC(1'b0)) dut_b (
    .clk(clk), .rst(rst), .cs(cs_b), .rxd_flag(flag_b), .rxd_out(rxd),
    .txd_data(txd_b), .reg_addr(addr_b), .reg_wdata(wdata_b), .reg_we(we_b),
    .reg_re(re_b), .reg_rdata(rdata_b), .frame_active(act_b), .cmd_err(err_b)
  );

  assign rdata_b = 8'h00;

  // Synchronous register file: read data valid the clk after reg_re.
  always @(posedge clk) begin
    if (re_a) rdata_a <= mem_a[addr_a];
    if (we_a) mem_a[addr_a] <= wdata_a;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic unexp(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s unexpected event actual=%0h required=none", nm, act);
  endtask

  // Monitor: pops the expected queues whenever the DUTs present bus strobes or a new MISO byte.
  always @(negedge clk) begin
    if (mon_en) begin
      if (we_a) begin
        if (exp_wr_a.size() == 0) unexp("wr_a", {17'd0, addr_a, wdata_a});
        else begin
          mw = exp_wr_a.pop_front();
          chk("wr_a", {17'd0, addr_a, wdata_a}, {17'd0, mw.a, mw.d});
        end
      end
      if (re_a) begin
        if (exp_rd_a.size() == 0) unexp("rd_a", {25'd0, addr_a});
        else begin
          mr = exp_rd_a.pop_front();
          chk("rd_a", {25'd0, addr_a}, {25'd0, mr});
        end
      end
      if (txd_a !== last_txd_a) begin
        if (exp_txd_a.size() == 0) unexp("txd_a", {24'd0, txd_a});
        else begin
          mt = exp_txd_a.pop_front();
          chk("txd_a", {24'd0, txd_a}, {24'd0, mt});
        end
        last_txd_a = txd_a;
      end
      if (we_b) begin
        if (exp_wr_b.size() == 0) unexp("wr_b", {17'd0, addr_b, wdata_b});
        else begin
          mw = exp_wr_b.pop_front();
          chk("wr_b", {17'd0, addr_b, wdata_b}, {17'd0, mw.a, mw.d});
        end
      end
      if (re_b) unexp("rd_b", {25'd0, addr_b});
      if (txd_b !== last_txd_b) begin
        unexp("txd_b", {24'd0, txd_b});
        last_txd_b = txd_b;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cs(input int w, input logic v);
    if (w == 0) cs_a = v; else cs_b = v;
  endtask

  task automatic set_flag(input int w, input logic v);
    if (w == 0) flag_a = v; else flag_b = v;
  endtask

  task automatic send_byte(input int w, input logic [7:0] b);
    @(negedge clk);
    rxd = b;
    set_flag(w, 1'b1);
    @(negedge clk);
    set_flag(w, 1'b0);
    tick(GAP);
  endtask

  task automatic start_frame(input int w);
    @(negedge clk);
    set_cs(w, 1'b0);
    tick(5);
  endtask

  task automatic end_frame(input int w);
    @(negedge clk);
    set_cs(w, 1'b1);
    tick(5);
  endtask

  // Last byte's flag lands in the same clk that the synchronised cs rise is seen.
  task automatic race_byte_end(input int w, input logic [7:0] b);
    @(negedge clk);
    set_cs(w, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rxd = b;
    set_flag(w, 1'b1);
    if (w == 0) chk("race_act_before", {31'd0, act_a}, 32'd1);
    @(negedge clk);
    set_flag(w, 1'b0);
    if (w == 0) chk("race_act_after", {31'd0, act_a}, 32'd0);
    tick(5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem_a[i] = 8'(i);
    mem_a[7'h10] = 8'hC1; mem_a[7'h11] = 8'hC2; mem_a[7'h12] = 8'hC3; mem_a[7'h13] = 8'hC4;
    mem_a[7'h20] = 8'hD0; mem_a[7'h21] = 8'hD1; mem_a[7'h22] = 8'hD2;

    // Reset state
    tick(3);
    chk("rst_txd", {24'd0, txd_a}, 32'hA5);
    chk("rst_addr", {25'd0, addr_a}, 32'd0);
    chk("rst_wdata", {24'd0, wdata_a}, 32'd0);
    chk("rst_we_re", {30'd0, we_a, re_a}, 32'd0);
    chk("rst_act_err", {30'd0, act_a, err_a}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick(3);

    // Write burst at 5,6,7
    exp_wr_a.push_back('{7'h05, 8'h11});
    exp_wr_a.push_back('{7'h06, 8'h22});
    exp_wr_a.push_back('{7'h07, 8'h33});
    start_frame(0);
    chk("wr_frame_act", {31'd0, act_a}, 32'd1);
    send_byte(0, 8'h05);
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    send_byte(0, 8'h33);
    end_frame(0);
    chk("wr_frame_end", {30'd0, act_a, err_a}, 32'd0);

    // Read burst from 0x10; the fourth byte collides with cs rise, so the only
    // trailing prefetch is 0x13.
    exp_rd_a.push_back(7'h10); exp_rd_a.push_back(7'h11);
    exp_rd_a.push_back(7'h12); exp_rd_a.push_back(7'h13);
    exp_txd_a.push_back(8'hC1); exp_txd_a.push_back(8'hC2);
    exp_txd_a.push_back(8'hC3); exp_txd_a.push_back(8'hA5);
    start_frame(0);
    @(negedge clk);
    rxd = 8'h90;
    flag_a = 1'b1;
    @(negedge clk);
    flag_a = 1'b0;
    @(negedge clk);
    chk("rd_lat2_txd", {24'd0, txd_a}, 32'hA5);
    @(negedge clk);
    chk("rd_lat3_txd", {24'd0, txd_a}, 32'hC1);
    tick(GAP);
    send_byte(0, 8'h00);
    send_byte(0, 8'h00);
    race_byte_end(0, 8'h00);

    // Address wrap with auto-increment, then with a fixed address
    exp_wr_a.push_back('{7'h7F, 8'hAA});
    exp_wr_a.push_back('{7'h00, 8'hBB});
    start_frame(0);
    send_byte(0, 8'h7F);
    send_byte(0, 8'hAA);
    send_byte(0, 8'hBB);
    end_frame(0);
    exp_wr_b.push_back('{7'h7F, 8'hAA});
    exp_wr_b.push_back('{7'h7F, 8'hBB});
    start_frame(1);
    send_byte(1, 8'h7F);
    send_byte(1, 8'hAA);
    send_byte(1, 8'hBB);
    end_frame(1);
    chk("b_err", {31'd0, err_b}, 32'd0);

    // Aborted frame: no command byte
    start_frame(0);
    tick(8);
    end_frame(0);
    chk("abort_err", {31'd0, err_a}, 32'd1);
    chk("abort_act", {31'd0, act_a}, 32'd0);
    exp_wr_a.push_back('{7'h01, 8'h77});
    start_frame(0);
    chk("abort_clear", {31'd0, err_a}, 32'd0);
    send_byte(0, 8'h01);
    send_byte(0, 8'h77);
    end_frame(0);
    chk("abort_next_err", {31'd0, err_a}, 32'd0);

    // cs rise and rxd_flag together in WR: byte dropped
    exp_wr_a.push_back('{7'h08, 8'h44});
    start_frame(0);
    send_byte(0, 8'h08);
    send_byte(0, 8'h44);
    race_byte_end(0, 8'h55);
    chk("race_err", {31'd0, err_a}, 32'd0);

    // Async reset in the middle of a read stream
    exp_rd_a.push_back(7'h20); exp_rd_a.push_back(7'h21);
    exp_txd_a.push_back(8'hD0); exp_txd_a.push_back(8'hA5);
    start_frame(0);
    send_byte(0, 8'hA0);
    @(negedge clk);
    rxd = 8'h00;
    flag_a = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_re", {31'd0, re_a}, 32'd1);
    chk("pre_rst_txd", {24'd0, txd_a}, 32'hD1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_txd", {24'd0, txd_a}, 32'hA5);
    chk("mid_rst_act", {31'd0, act_a}, 32'd0);
    chk("mid_rst_re", {31'd0, re_a}, 32'd0);
    @(negedge clk);
    flag_a = 1'b0;
    cs_a = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(5);
    exp_wr_a.push_back('{7'h03, 8'h5A});
    start_frame(0);
    send_byte(0, 8'h03);
    send_byte(0, 8'h5A);
    end_frame(0);

    tick(10);
    chk("left_wr_a", exp_wr_a.size(), 32'd0);
    chk("left_rd_a", exp_rd_a.size(), 32'd0);
    chk("left_txd_a", exp_txd_a.size(), 32'd0);
    chk("left_wr_b", exp_wr_b.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
